// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle for the weighted round-robin arbiter.
// The requester side drives req/weight/gnt_ready; the arbiter drives the grant.
interface weighted_rr_arbiter_if #(
   parameter int unsigned NUM_REQUESTS = 4,
   parameter int unsigned WEIGHT_W     = 4
);
   localparam int unsigned IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

   logic [NUM_REQUESTS-1:0]          req;
   logic [NUM_REQUESTS*WEIGHT_W-1:0] weight;
   logic                             gnt_ready;
   logic                             gnt_valid;
   logic [IDX_W-1:0]                 gnt;
   logic [NUM_REQUESTS-1:0]          gnt_onehot;

   modport master (
      output req,
      output weight,
      output gnt_ready,
      input  gnt_valid,
      input  gnt,
      input  gnt_onehot
   );

   modport slave (
      input  req,
      input  weight,
      input  gnt_ready,
      output gnt_valid,
      output gnt,
      output gnt_onehot
   );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with a registered, sticky grant.
// A selected owner keeps the grant for up to eff_weight accepted transfers while it
// keeps requesting; then the search pointer moves past it. Zero weight counts as 1.
module weighted_rr_arbiter #(
   parameter int unsigned NUM_REQUESTS = 4,
   parameter int unsigned WEIGHT_W     = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   weighted_rr_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTS - 1);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [WEIGHT_W-1:0]     credit_q, credit_d;
   logic [NUM_REQUESTS-1:0] onehot_q, onehot_d;

   logic [WEIGHT_W-1:0]     weight_arr [NUM_REQUESTS];
   logic [IDX_W-1:0]        rot_ptr;
   logic [IDX_W-1:0]        scan_start;
   logic [IDX_W-1:0]        winner;
   logic                    winner_found;
   logic [WEIGHT_W-1:0]     win_weight;
   logic [WEIGHT_W-1:0]     win_credit;

   // Unpack the flat weight bus into per-requester fields.
   always_comb begin : unpack_weights
      for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
         weight_arr[i] = bus.weight[i*WEIGHT_W +: WEIGHT_W];
      end
   end

   // Pointer that follows the current owner, wrapping after the last requester.
   always_comb begin : rotate_ptr
      rot_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
   end

   // Circular scan for the first active request; at rotation the scan already starts
   // past the owner so the new grant lands in the same cycle the pointer moves.
   always_comb begin : scan
      int unsigned idx;
      idx          = 0;
      scan_start   = (state_q == StGrant) ? rot_ptr : ptr_q;
      winner       = '0;
      winner_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQUESTS; k++) begin
         idx = 32'(scan_start) + k;
         if (idx >= NUM_REQUESTS) begin
            idx = idx - NUM_REQUESTS;
         end
         if (!winner_found && bus.req[IDX_W'(idx)]) begin
            winner       = IDX_W'(idx);
            winner_found = 1'b1;
         end
      end
   end

   // Re-grants left for a newly selected owner: eff_weight - 1, zero weight acting as 1.
   always_comb begin : credit_calc
      win_weight = weight_arr[winner];
      win_credit = (win_weight == '0) ? '0 : win_weight - 1'b1;
   end

   // Next-state logic: idle pickup, sticky hold, burst re-grant, or rotation.
   always_comb begin : fsm_next
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      credit_d = credit_q;
      onehot_d = onehot_q;
      unique case (state_q)
         StIdle: begin
            if (winner_found) begin
               state_d          = StGrant;
               owner_d          = winner;
               credit_d         = win_credit;
               onehot_d         = '0;
               onehot_d[winner] = 1'b1;
            end
         end
         StGrant: begin
            if (bus.gnt_ready) begin
               if ((credit_q != '0) && bus.req[owner_q]) begin
                  credit_d = credit_q - 1'b1;
               end else begin
                  // Leftover credit is dropped here whether or not anyone requests.
                  ptr_d = rot_ptr;
                  if (winner_found) begin
                     owner_d          = winner;
                     credit_d         = win_credit;
                     onehot_d         = '0;
                     onehot_d[winner] = 1'b1;
                  end else begin
                     state_d  = StIdle;
                     credit_d = '0;
                     onehot_d = '0;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register; reset clears all burst state without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
      if (!rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
         onehot_q <= onehot_d;
      end
   end

   // Outputs come straight from registers: no path from req or gnt_ready.
   assign bus.gnt_valid  = (state_q == StGrant);
   assign bus.gnt        = owner_q;
   assign bus.gnt_onehot = onehot_q;
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter: directed scenarios plus random traffic,
// every cycle compared against a burst-counting reference model.
module tb_weighted_rr_arbiter;
   localparam int N = 4;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   // Reference model: current owner, grants used in this burst, and burst budget.
   bit m_valid;
   int m_owner;
   int m_ptr;
   int m_used;
   int m_budget;

   int exp27[6] = '{0, 1, 2, 3, 0, 1};
   int exp28[8] = '{0, 0, 0, 1, 2, 2, 3, 0};
   int exp31[4] = '{0, 1, 0, 1};

   weighted_rr_arbiter_if #(.NUM_REQUESTS(N), .WEIGHT_W(W)) bus ();

   weighted_rr_arbiter #(.NUM_REQUESTS(N), .WEIGHT_W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int start, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (start + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic int effw(input int i);
      int v;
      v = int'(bus.weight[i*W +: W]);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic new_burst(input int w);
      m_valid  = 1'b1;
      m_owner  = w;
      m_budget = effw(w);
      m_used   = 1;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int w;
      if (!m_valid) begin
         w = pick(m_ptr, bus.req);
         if (w >= 0) new_burst(w);
      end else if (bus.gnt_ready) begin
         if (m_used < m_budget && bus.req[m_owner]) begin
            m_used++;
         end else begin
            m_ptr = (m_owner + 1) % N;
            w     = pick(m_ptr, bus.req);
            if (w >= 0) new_burst(w);
            else m_valid = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("valid", 32'(bus.gnt_valid), 32'(m_valid));
      chk("onehot", 32'(bus.gnt_onehot), m_valid ? (32'd1 << m_owner) : 32'd0);
      if (m_valid) chk("gnt", 32'(bus.gnt), 32'(m_owner));
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req       = '0;
      bus.gnt_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
      m_valid = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_used  = 0;
      m_budget = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
      bus.weight = {W'(w3), W'(w2), W'(w1), W'(w0)};
   endtask

   initial begin
      bus.req       = '0;
      bus.weight    = '0;
      bus.gnt_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // All weights 1: plain round robin starting from index 0.
      set_weights(1, 1, 1, 1);
      bus.req       = 4'b1111;
      bus.gnt_ready = 1'b1;
      #1;
      chk("r27_no_comb_valid", 32'(bus.gnt_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("r27_seq", 32'(bus.gnt), 32'(exp27[i]));
      end

      // Weighted bursts.
      do_reset();
      set_weights(3, 1, 2, 1);
      bus.req       = 4'b1111;
      bus.gnt_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("r28_seq", 32'(bus.gnt), 32'(exp28[i]));
      end

      // Sticky grant while stalled, request pattern changing underneath.
      do_reset();
      set_weights(1, 1, 1, 1);
      bus.req = 4'b0100;
      cycle();
      chk("r29_first", 32'(bus.gnt), 32'd2);
      for (int i = 0; i < 5; i++) begin
         bus.req = (i < 2) ? 4'b0100 : 4'b0001;
         cycle();
         chk("r29_hold_gnt", 32'(bus.gnt), 32'd2);
         chk("r29_hold_onehot", 32'(bus.gnt_onehot), 32'b0100);
      end
      bus.gnt_ready = 1'b1;
      cycle();
      chk("r29_after", 32'(bus.gnt), 32'd0);

      // Owner drops its request mid-burst; remaining credit is discarded.
      do_reset();
      set_weights(1, 3, 1, 1);
      bus.req = 4'b1010;
      cycle();
      chk("r30_first", 32'(bus.gnt), 32'd1);
      bus.gnt_ready = 1'b1;
      cycle();
      chk("r30_regrant", 32'(bus.gnt), 32'd1);
      bus.req = 4'b1000;
      cycle();
      chk("r30_switch", 32'(bus.gnt), 32'd3);
      bus.req = 4'b1010;
      cycle();
      chk("r30_back", 32'(bus.gnt), 32'd1);

      // Zero weight behaves as weight 1.
      do_reset();
      set_weights(0, 1, 1, 1);
      bus.req       = 4'b0011;
      bus.gnt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("r31_seq", 32'(bus.gnt), 32'(exp31[i]));
      end

      // Lone owner at rotation is re-granted with fresh credit; pointer wraps from 3.
      do_reset();
      set_weights(1, 1, 1, 2);
      bus.req       = 4'b1000;
      bus.gnt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("lone_owner", 32'(bus.gnt), 32'd3);
      end

      // Reset mid-grant, then first arbitration searches from index 0.
      do_reset();
      set_weights(1, 1, 1, 1);
      bus.req = 4'b1000;
      cycle();
      chk("r32_pre", 32'(bus.gnt), 32'd3);
      do_reset();
      bus.req = 4'b1010;
      cycle();
      chk("r32_post", 32'(bus.gnt), 32'd1);

      // Random traffic with occasional weight changes and resets.
      do_reset();
      set_weights($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      for (int i = 0; i < 600; i++) begin
         if (i % 200 == 199) do_reset();
         if (i % 37 == 0) begin
            set_weights($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 4));
         end
         bus.req       = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
         bus.gnt_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
